// File: rtl/lsu_pkg.sv
// Shared types, size encodings and alignment check for the load/store unit.
package lsu_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRead,
      StWrite,
      StResp
   } state_t;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   // Layout matches the req_op port: {store, unsigned, size[1:0]}
   typedef struct packed {
      logic       store;
      logic       uns;
      logic [1:0] size;
   } op_t;

   // Natural alignment check; the reserved size is handled separately
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr);
      case (size)
         SZ_H:    return addr[0];
         SZ_W:    return addr != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: load extract/extend and sub-word store merge (little-endian).
module lsu_align
   import lsu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  off,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] store_word
);

   logic [31:0] shifted;

   // Right-justify the addressed lane, then zero- or sign-extend
   always_comb begin
      shifted   = rdata >> {off, 3'b000};
      load_data = shifted;
      case (size)
         SZ_B: load_data = is_unsigned ? {24'd0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
         SZ_H: load_data = is_unsigned ? {16'd0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
         default: load_data = rdata;
      endcase
   end

   // Overlay the low byte/half of the store data onto the old word
   always_comb begin
      store_word = rdata;
      case (size)
         SZ_B:    store_word[{off, 3'b000} +: 8]       = wdata[7:0];
         SZ_H:    store_word[{off[1], 4'b0000} +: 16]  = wdata[15:0];
         SZ_W:    store_word                           = wdata;
         default: store_word                           = rdata;
      endcase
   end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit driving the umem data port; one request in flight at a time.
// Sub-word stores are read-modify-write because the port has no byte enables.
module dmem_lsu
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_LATENCY = 1, // legal 1..7
   parameter int unsigned RD_W        = 5
) (
   input  logic            clk,
   input  logic            nreset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [3:0]      req_op,
   input  logic [31:0]     req_addr,
   input  logic [31:0]     req_wdata,
   input  logic [RD_W-1:0] req_rd,
   output logic            rsp_valid,
   output logic [RD_W-1:0] rsp_rd,
   output logic [31:0]     rsp_data,
   output logic            rsp_err,
   output logic [31:0]     mem_addr,
   output logic [31:0]     mem_wdata,
   output logic            mem_rw,
   input  logic [31:0]     mem_rdata
);

   localparam logic [2:0] LAT = 3'(MEM_LATENCY);

   state_t          state;
   op_t             op_r;
   op_t             req_op_s;
   logic [1:0]      off_r;
   logic [31:0]     wdata_r;
   logic [RD_W-1:0] rd_r;
   logic [2:0]      cnt;
   logic [31:0]     load_data;
   logic [31:0]     store_word;
   logic            req_bad;

   assign req_op_s  = op_t'(req_op);
   assign req_bad   = (req_op_s.size == 2'd3) || misaligned(req_op_s.size, req_addr[1:0]);
   assign req_ready = (state == StIdle);

   lsu_align u_align (
      .rdata       (mem_rdata),
      .off         (off_r),
      .size        (op_r.size),
      .is_unsigned (op_r.uns),
      .wdata       (wdata_r),
      .load_data   (load_data),
      .store_word  (store_word)
   );

   // Request FSM with registered memory-port and response outputs
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state     <= StIdle;
         op_r      <= '0;
         off_r     <= '0;
         wdata_r   <= '0;
         rd_r      <= '0;
         cnt       <= '0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rd    <= '0;
         rsp_data  <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_rw    <= 1'b0;
      end else begin
         case (state)
            StIdle: begin
               if (req_valid) begin
                  op_r    <= req_op_s;
                  off_r   <= req_addr[1:0];
                  wdata_r <= req_wdata;
                  rd_r    <= req_rd;
                  cnt     <= '0;
                  if (req_bad) begin
                     // Errors never touch memory
                     state     <= StResp;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rd    <= '0;
                     rsp_data  <= '0;
                  end else if (req_op_s.store && (req_op_s.size == SZ_W)) begin
                     state     <= StWrite;
                     mem_addr  <= {req_addr[31:2], 2'b00};
                     mem_wdata <= req_wdata;
                     mem_rw    <= 1'b1;
                  end else begin
                     // Loads and the read half of sub-word stores
                     state    <= StRead;
                     mem_addr <= {req_addr[31:2], 2'b00};
                     mem_rw   <= 1'b0;
                  end
               end
            end
            StRead: begin
               if (cnt == LAT) begin
                  if (op_r.store) begin
                     state     <= StWrite;
                     mem_wdata <= store_word;
                     mem_rw    <= 1'b1;
                  end else begin
                     state     <= StResp;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b0;
                     rsp_rd    <= rd_r;
                     rsp_data  <= load_data;
                  end
               end else begin
                  cnt <= cnt + 3'd1;
               end
            end
            StWrite: begin
               state     <= StResp;
               mem_rw    <= 1'b0;
               rsp_valid <= 1'b1;
               rsp_err   <= 1'b0;
               rsp_rd    <= '0;
               rsp_data  <= '0;
            end
            StResp: begin
               state     <= StIdle;
               rsp_valid <= 1'b0;
               rsp_err   <= 1'b0;
               rsp_rd    <= '0;
               rsp_data  <= '0;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: one instance at latency 1, one at latency 3.
module tb_dmem_lsu;

   localparam logic [31:0] GARB = 32'h5A5A_5A5A;

   logic        clk;
   logic        nreset;
   logic        req_valid;
   logic        sel;
   logic [3:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [4:0]  req_rd;
   logic [31:0] mem_rdata;

   logic        ready1, rsp_valid1, rsp_err1, rw1;
   logic [4:0]  rsp_rd1;
   logic [31:0] rsp_data1, addr1, wdata1;
   logic        ready3, rsp_valid3, rsp_err3, rw3;
   logic [4:0]  rsp_rd3;
   logic [31:0] rsp_data3, addr3, wdata3;

   logic        o_ready, o_rsp_valid, o_rsp_err, o_rw;
   logic [4:0]  o_rsp_rd;
   logic [31:0] o_rsp_data, o_addr, o_wdata;

   int checks = 0;
   int errors = 0;

   dmem_lsu #(.MEM_LATENCY(1), .RD_W(5)) u_dut1 (
      .clk       (clk),
      .nreset    (nreset),
      .req_valid (req_valid & ~sel),
      .req_ready (ready1),
      .req_op    (req_op),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_rd    (req_rd),
      .rsp_valid (rsp_valid1),
      .rsp_rd    (rsp_rd1),
      .rsp_data  (rsp_data1),
      .rsp_err   (rsp_err1),
      .mem_addr  (addr1),
      .mem_wdata (wdata1),
      .mem_rw    (rw1),
      .mem_rdata (mem_rdata)
   );

   dmem_lsu #(.MEM_LATENCY(3), .RD_W(5)) u_dut3 (
      .clk       (clk),
      .nreset    (nreset),
      .req_valid (req_valid & sel),
      .req_ready (ready3),
      .req_op    (req_op),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_rd    (req_rd),
      .rsp_valid (rsp_valid3),
      .rsp_rd    (rsp_rd3),
      .rsp_data  (rsp_data3),
      .rsp_err   (rsp_err3),
      .mem_addr  (addr3),
      .mem_wdata (wdata3),
      .mem_rw    (rw3),
      .mem_rdata (mem_rdata)
   );

   assign o_ready     = sel ? ready3     : ready1;
   assign o_rsp_valid = sel ? rsp_valid3 : rsp_valid1;
   assign o_rsp_err   = sel ? rsp_err3   : rsp_err1;
   assign o_rw        = sel ? rw3        : rw1;
   assign o_rsp_rd    = sel ? rsp_rd3    : rsp_rd1;
   assign o_rsp_data  = sel ? rsp_data3  : rsp_data1;
   assign o_addr      = sel ? addr3      : addr1;
   assign o_wdata     = sel ? wdata3     : wdata1;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] b2w(input logic b);
      return {31'd0, b};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   typedef struct {
      string       name;
      logic        sel;       // 0: latency-1 DUT, 1: latency-3 DUT
      logic [3:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [4:0]  rd;
      logic [31:0] word;      // memory word returned on the sampling cycle
      bit          rd_phase;  // a read is issued
      int          wr_cyc;    // cycle offset of the write (0 = none)
      int          rsp_cyc;   // cycle offset of rsp_valid
      logic [31:0] exp_wdata;
      logic [31:0] exp_data;
      logic [4:0]  exp_rd;
      bit          exp_err;
   } vec_t;

   vec_t vecs[11];

   // Drive one request and check every output cycle by cycle until back in idle
   task automatic run_vec(input vec_t v);
      int lat;
      logic [31:0] waddr;
      lat   = v.sel ? 3 : 1;
      waddr = {v.addr[31:2], 2'b00};
      @(negedge clk);
      sel = v.sel;
      #1;
      chk({v.name, "/ready_a"}, b2w(o_ready), 32'd1);
      req_op    = v.op;
      req_addr  = v.addr;
      req_wdata = v.wdata;
      req_rd    = v.rd;
      req_valid = 1'b1;
      mem_rdata = GARB;
      @(posedge clk);
      for (int k = 1; k <= v.rsp_cyc + 1; k++) begin
         @(negedge clk);
         req_valid = 1'b0;
         mem_rdata = (v.rd_phase && k == 1 + lat) ? v.word : GARB;
         chk($sformatf("%s/rw@%0d", v.name, k), b2w(o_rw), b2w(k == v.wr_cyc));
         if (v.rd_phase && k <= 1 + lat)
            chk($sformatf("%s/raddr@%0d", v.name, k), o_addr, waddr);
         if (k == v.wr_cyc) begin
            chk({v.name, "/waddr"}, o_addr, waddr);
            chk({v.name, "/wdata"}, o_wdata, v.exp_wdata);
         end
         chk($sformatf("%s/rsp_valid@%0d", v.name, k), b2w(o_rsp_valid),
             b2w(k == v.rsp_cyc));
         if (k == v.rsp_cyc) begin
            chk({v.name, "/rsp_data"}, o_rsp_data, v.exp_data);
            chk({v.name, "/rsp_rd"}, {27'd0, o_rsp_rd}, {27'd0, v.exp_rd});
            chk({v.name, "/rsp_err"}, b2w(o_rsp_err), b2w(v.exp_err));
         end
         chk($sformatf("%s/ready@%0d", v.name, k), b2w(o_ready), b2w(k == v.rsp_cyc + 1));
      end
   endtask

   initial begin
      //          name    sel  op     addr          wdata         rd     word          rdp wr rsp exp_wdata     exp_data      erd    err
      vecs[0]  = '{"LW",    0, 4'h2, 32'h100, 32'h0,         5'd5,  32'hDEADBEEF, 1, 0, 3, 32'h0,         32'hDEADBEEF, 5'd5,  0};
      vecs[1]  = '{"LB",    0, 4'h0, 32'h103, 32'h0,         5'd6,  32'h80FF1234, 1, 0, 3, 32'h0,         32'hFFFFFF80, 5'd6,  0};
      vecs[2]  = '{"LBU",   0, 4'h4, 32'h103, 32'h0,         5'd7,  32'h80FF1234, 1, 0, 3, 32'h0,         32'h00000080, 5'd7,  0};
      vecs[3]  = '{"SB",    0, 4'h8, 32'h102, 32'h000000AB,  5'd9,  32'h11223344, 1, 3, 4, 32'h11AB3344,  32'h0,        5'd0,  0};
      vecs[4]  = '{"SW",    0, 4'hA, 32'h104, 32'hCAFEF00D,  5'd3,  32'h0,        0, 1, 2, 32'hCAFEF00D,  32'h0,        5'd0,  0};
      vecs[5]  = '{"LHmis", 0, 4'h1, 32'h101, 32'h0,         5'd4,  32'h0,        0, 0, 1, 32'h0,         32'h0,        5'd0,  1};
      vecs[6]  = '{"SWmis", 0, 4'hA, 32'h102, 32'h12345678,  5'd4,  32'h0,        0, 0, 1, 32'h0,         32'h0,        5'd0,  1};
      vecs[7]  = '{"SZ3",   0, 4'h3, 32'h100, 32'h0,         5'd8,  32'h0,        0, 0, 1, 32'h0,         32'h0,        5'd0,  1};
      vecs[8]  = '{"LH",    0, 4'h1, 32'h102, 32'h0,         5'd10, 32'h80017777, 1, 0, 3, 32'h0,         32'hFFFF8001, 5'd10, 0};
      vecs[9]  = '{"SH",    0, 4'h9, 32'h100, 32'h1234BEEF,  5'd11, 32'hAAAABBBB, 1, 3, 4, 32'hAAAABEEF,  32'h0,        5'd0,  0};
      vecs[10] = '{"LHU3",  1, 4'h5, 32'h102, 32'h0,         5'd12, 32'hBEEF0000, 1, 0, 5, 32'h0,         32'h0000BEEF, 5'd12, 0};

      nreset    = 1'b0;
      req_valid = 1'b0;
      sel       = 1'b0;
      req_op    = '0;
      req_addr  = '0;
      req_wdata = '0;
      req_rd    = '0;
      mem_rdata = GARB;

      #2;
      chk("reset/ready", b2w(ready1), 32'd1);
      chk("reset/rsp_valid", b2w(rsp_valid1), 32'd0);
      chk("reset/rsp_err", b2w(rsp_err1), 32'd0);
      chk("reset/rsp_data", rsp_data1, 32'd0);
      chk("reset/rsp_rd", {27'd0, rsp_rd1}, 32'd0);
      chk("reset/mem_addr", addr1, 32'd0);
      chk("reset/mem_wdata", wdata1, 32'd0);
      chk("reset/mem_rw", b2w(rw1), 32'd0);
      chk("reset/mem_rw3", b2w(rw3), 32'd0);
      repeat (2) @(negedge clk);
      nreset = 1'b1;

      for (int i = 0; i < 11; i++) run_vec(vecs[i]);

      // Reset during the write cycle of a word store
      @(negedge clk);
      sel       = 1'b0;
      req_op    = 4'hA;
      req_addr  = 32'h108;
      req_wdata = 32'h0BADF00D;
      req_rd    = 5'd2;
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("rstmid/rw_before", b2w(rw1), 32'd1);
      #1 nreset = 1'b0;
      #1;
      chk("rstmid/rw_after", b2w(rw1), 32'd0);
      chk("rstmid/ready", b2w(ready1), 32'd1);
      @(negedge clk);
      nreset = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("rstmid/no_rsp@%0d", k), b2w(rsp_valid1), 32'd0);
         chk($sformatf("rstmid/rw@%0d", k), b2w(rw1), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
